// File: rtl/twiddle_seq_gen.sv
// Radix-2 DIT twiddle sequence generator: streams W_N^k for one FFT stage over valid/ready.
// Optional macro TWIDDLE_INV_EN adds req_inv, which conjugates the stream for IFFT use.
module twiddle_seq_gen #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int LOG2_N = 4,
  localparam int STAGE_W = ($clog2(LOG2_N) < 1) ? 1 : $clog2(LOG2_N),
  localparam int IDX_W = LOG2_N - 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [STAGE_W-1:0] req_stage,
`ifdef TWIDDLE_INV_EN
  input  logic               req_inv,
`endif
  output logic               tw_valid,
  input  logic               tw_ready,
  output logic [DATA_W-1:0]  tw_re,
  output logic [DATA_W-1:0]  tw_im,
  output logic [IDX_W-1:0]   tw_idx,
  output logic               tw_last,
  output logic               stage_err
);

  localparam int N = 1 << LOG2_N;
  localparam int QTR = N / 4;
  localparam int TBL_W = FRAC_W + 1;
  localparam logic [IDX_W-1:0] J_LAST = IDX_W'(N / 2 - 1);
  localparam logic [IDX_W-1:0] QTR_V = IDX_W'(QTR);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // Taylor series keeps the quarter-wave table a pure elaboration-time constant.
  function automatic int sin_lut(input int i);
    real x, term, sum;
    x = 2.0 * 3.14159265358979323846 * real'(i) / real'(N);
    term = x;
    sum = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / ((2.0 * n) * (2.0 * n + 1.0));
      sum += term;
    end
    return $rtoi(sum * real'(1 << FRAC_W) + 0.5);
  endfunction

  logic [TBL_W-1:0] tbl [QTR+1];

  for (genvar g = 0; g <= QTR; g++) begin : g_tbl
    localparam int TBL_VAL = sin_lut(g);
    assign tbl[g] = TBL_W'(TBL_VAL);
  end

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   j_q, j_d;
  logic [STAGE_W-1:0] s_q, s_d;
  logic               inv_q, inv_d;
  logic               req_ready_q, req_ready_d;
  logic               stage_err_q, stage_err_d;

  logic               s1_valid_q, s1_valid_d;
  logic               s1_last_q, s1_last_d;
  logic [IDX_W-1:0]   s1_k_q, s1_k_d;
  logic [IDX_W-1:0]   s1_re_addr_q, s1_re_addr_d;
  logic [IDX_W-1:0]   s1_im_addr_q, s1_im_addr_d;
  logic               s1_re_neg_q, s1_re_neg_d;
  logic               s1_im_neg_q, s1_im_neg_d;

  logic               tw_valid_q, tw_valid_d;
  logic               tw_last_q, tw_last_d;
  logic [IDX_W-1:0]   tw_idx_q, tw_idx_d;
  logic [DATA_W-1:0]  tw_re_q, tw_re_d;
  logic [DATA_W-1:0]  tw_im_q, tw_im_d;

  logic               stall, issue, req_inv_c;
  logic [IDX_W-1:0]   mask_c, k_c;
  logic [DATA_W-1:0]  re_ext_c, im_ext_c;

`ifdef TWIDDLE_INV_EN
  assign req_inv_c = req_inv;
`else
  assign req_inv_c = 1'b0;
`endif

  assign stall = tw_valid_q & ~tw_ready;
  assign issue = (state_q == RUN) & ~stall;

  always_comb begin
    state_d     = state_q;
    j_d         = j_q;
    s_d         = s_q;
    inv_d       = inv_q;
    req_ready_d = req_ready_q;
    stage_err_d = stage_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d     = RUN;
          j_d         = '0;
          inv_d       = req_inv_c;
          req_ready_d = 1'b0;
          if (int'(req_stage) >= LOG2_N) begin
            stage_err_d = 1'b1;
            s_d         = STAGE_W'(LOG2_N - 1);
          end else begin
            stage_err_d = 1'b0;
            s_d         = req_stage;
          end
        end
      end
      RUN: begin
        if (issue) begin
          j_d = j_q + IDX_W'(1);
          if (j_q == J_LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (tw_valid_q && tw_ready && tw_last_q) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage 1: exponent k from butterfly index, then fold into the quarter-wave table.
  always_comb begin
    mask_c = IDX_W'((1 << s_q) - 1);
    k_c    = IDX_W'(32'(j_q & mask_c) << (IDX_W - 32'(s_q)));

    s1_valid_d   = s1_valid_q;
    s1_last_d    = s1_last_q;
    s1_k_d       = s1_k_q;
    s1_re_addr_d = s1_re_addr_q;
    s1_im_addr_d = s1_im_addr_q;
    s1_re_neg_d  = s1_re_neg_q;
    s1_im_neg_d  = s1_im_neg_q;
    if (!stall) begin
      s1_valid_d  = issue;
      s1_last_d   = issue && (j_q == J_LAST);
      s1_k_d      = k_c;
      s1_im_neg_d = inv_q;
      if (k_c <= QTR_V) begin
        s1_re_addr_d = QTR_V - k_c;
        s1_im_addr_d = k_c;
        s1_re_neg_d  = 1'b0;
      end else begin
        s1_re_addr_d = k_c - QTR_V;
        s1_im_addr_d = IDX_W'(N / 2 - int'(k_c));
        s1_re_neg_d  = 1'b1;
      end
    end
  end

  // Stage 2: table lookup, sign application and output register.
  always_comb begin
    re_ext_c = DATA_W'(tbl[s1_re_addr_q]);
    im_ext_c = DATA_W'(tbl[s1_im_addr_q]);

    tw_valid_d = tw_valid_q;
    tw_last_d  = tw_last_q;
    tw_idx_d   = tw_idx_q;
    tw_re_d    = tw_re_q;
    tw_im_d    = tw_im_q;
    if (!stall) begin
      tw_valid_d = s1_valid_q;
      tw_last_d  = s1_valid_q & s1_last_q;
      if (s1_valid_q) begin
        tw_idx_d = s1_k_q;
        tw_re_d  = s1_re_neg_q ? -re_ext_c : re_ext_c;
        tw_im_d  = s1_im_neg_q ? -im_ext_c : im_ext_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      j_q          <= '0;
      s_q          <= '0;
      inv_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      stage_err_q  <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_k_q       <= '0;
      s1_re_addr_q <= '0;
      s1_im_addr_q <= '0;
      s1_re_neg_q  <= 1'b0;
      s1_im_neg_q  <= 1'b0;
      tw_valid_q   <= 1'b0;
      tw_last_q    <= 1'b0;
      tw_idx_q     <= '0;
      tw_re_q      <= '0;
      tw_im_q      <= '0;
    end else begin
      state_q      <= state_d;
      j_q          <= j_d;
      s_q          <= s_d;
      inv_q        <= inv_d;
      req_ready_q  <= req_ready_d;
      stage_err_q  <= stage_err_d;
      s1_valid_q   <= s1_valid_d;
      s1_last_q    <= s1_last_d;
      s1_k_q       <= s1_k_d;
      s1_re_addr_q <= s1_re_addr_d;
      s1_im_addr_q <= s1_im_addr_d;
      s1_re_neg_q  <= s1_re_neg_d;
      s1_im_neg_q  <= s1_im_neg_d;
      tw_valid_q   <= tw_valid_d;
      tw_last_q    <= tw_last_d;
      tw_idx_q     <= tw_idx_d;
      tw_re_q      <= tw_re_d;
      tw_im_q      <= tw_im_d;
    end
  end

  assign req_ready = req_ready_q;
  assign stage_err = stage_err_q;
  assign tw_valid  = tw_valid_q;
  assign tw_last   = tw_last_q;
  assign tw_idx    = tw_idx_q;
  assign tw_re     = tw_re_q;
  assign tw_im     = tw_im_q;

endmodule

// File: tb/tb_twiddle_seq_gen.sv
// Scoreboard bench for twiddle_seq_gen: default 16-point instance plus a 32-point
// instance whose 3-bit stage port can express out-of-range requests.
module tb_twiddle_seq_gen;

  localparam int DATA_W  = 16;
  localparam int FRAC_W  = 8;
  localparam int LOG2_N  = 4;
  localparam int N       = 1 << LOG2_N;
  localparam int SW      = ($clog2(LOG2_N) < 1) ? 1 : $clog2(LOG2_N);
  localparam int LOG2_NB = 5;
  localparam int NB      = 1 << LOG2_NB;
  localparam int SWB     = ($clog2(LOG2_NB) < 1) ? 1 : $clog2(LOG2_NB);

  typedef struct {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
    int                idx;
    bit                last;
  } exp_t;

  logic clk, rst_n;
  logic req_valid, req_ready, tw_valid, tw_ready, tw_last, stage_err;
  logic [SW-1:0] req_stage;
  logic [DATA_W-1:0] tw_re, tw_im;
  logic [LOG2_N-2:0] tw_idx;
  logic req_inv;

  logic req_valid_b, req_ready_b, tw_valid_b, tw_ready_b, tw_last_b, stage_err_b;
  logic [SWB-1:0] req_stage_b;
  logic [DATA_W-1:0] tw_re_b, tw_im_b;
  logic [LOG2_NB-2:0] tw_idx_b;
  logic req_inv_b;

  exp_t qa[$];
  exp_t qb[$];
  int checks = 0;
  int failures = 0;

  twiddle_seq_gen #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .LOG2_N(LOG2_N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_stage(req_stage),
`ifdef TWIDDLE_INV_EN
    .req_inv(req_inv),
`endif
    .tw_valid(tw_valid), .tw_ready(tw_ready), .tw_re(tw_re), .tw_im(tw_im),
    .tw_idx(tw_idx), .tw_last(tw_last), .stage_err(stage_err)
  );

  twiddle_seq_gen #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .LOG2_N(LOG2_NB)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_stage(req_stage_b),
`ifdef TWIDDLE_INV_EN
    .req_inv(req_inv_b),
`endif
    .tw_valid(tw_valid_b), .tw_ready(tw_ready_b), .tw_re(tw_re_b), .tw_im(tw_im_b),
    .tw_idx(tw_idx_b), .tw_last(tw_last_b), .stage_err(stage_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: W = cos + j*sin rounded half away from zero, from the math library.
  function automatic exp_t model(input int n, input int log2n, input int j,
                                 input int stage, input bit inv);
    exp_t e;
    int s, k, re, im;
    real th, c, sn;
    s  = (stage >= log2n) ? log2n - 1 : stage;
    k  = (j % (1 << s)) << (log2n - 1 - s);
    th = 2.0 * 3.14159265358979323846 * real'(k) / real'(n);
    c  = $cos(th) * real'(1 << FRAC_W);
    sn = $sin(th) * real'(1 << FRAC_W);
    re = (c >= 0.0) ? $rtoi(c + 0.5) : -$rtoi(-c + 0.5);
    im = (sn >= 0.0) ? $rtoi(sn + 0.5) : -$rtoi(-sn + 0.5);
    if (inv) im = -im;
    e.re   = DATA_W'(re);
    e.im   = DATA_W'(im);
    e.idx  = k;
    e.last = (j == n / 2 - 1);
    return e;
  endfunction

  task automatic push_model_a(input int stage, input bit inv);
    for (int j = 0; j < N / 2; j++) qa.push_back(model(N, LOG2_N, j, stage, inv));
  endtask

  task automatic push_model_b(input int stage);
    for (int j = 0; j < NB / 2; j++) qb.push_back(model(NB, LOG2_NB, j, stage, 1'b0));
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst_n && tw_valid && tw_ready) begin
      checks++;
      if (qa.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_output_a got idx=%0d re=%h im=%h required no output",
                 tw_idx, tw_re, tw_im);
      end else begin
        e = qa.pop_front();
        if (tw_re !== e.re || tw_im !== e.im || int'(tw_idx) !== e.idx || tw_last !== e.last) begin
          failures++;
          $display("[TB] FAIL element_a got (re=%h im=%h idx=%0d last=%0b) required (re=%h im=%h idx=%0d last=%0b)",
                   tw_re, tw_im, tw_idx, tw_last, e.re, e.im, e.idx, e.last);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst_n && tw_valid_b && tw_ready_b) begin
      checks++;
      if (qb.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_output_b got idx=%0d required no output", tw_idx_b);
      end else begin
        e = qb.pop_front();
        if (tw_re_b !== e.re || tw_im_b !== e.im || int'(tw_idx_b) !== e.idx || tw_last_b !== e.last) begin
          failures++;
          $display("[TB] FAIL element_b got (re=%h im=%h idx=%0d last=%0b) required (re=%h im=%h idx=%0d last=%0b)",
                   tw_re_b, tw_im_b, tw_idx_b, tw_last_b, e.re, e.im, e.idx, e.last);
        end
      end
    end
  end

  task automatic send_req(input int stage);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_stage = SW'(stage);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic send_req_b(input int stage);
    @(posedge clk); #1;
    req_valid_b = 1'b1;
    req_stage_b = SWB'(stage);
    @(posedge clk); #1;
    req_valid_b = 1'b0;
  endtask

  task automatic wait_drain_a(input string name);
    int c = 0;
    while (!(qa.size() == 0 && req_ready) && c < 300) begin
      @(posedge clk); #1;
      c++;
    end
    checks++;
    if (c >= 300) begin
      failures++;
      $display("[TB] FAIL %s_drain got pending=%0d req_ready=%0b required 0 and 1", name, qa.size(), req_ready);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #23;
    checks++;
    if (req_ready !== 1'b1 || tw_valid !== 1'b0 || tw_last !== 1'b0 || tw_re !== '0 ||
        tw_im !== '0 || tw_idx !== '0 || stage_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_state got rdy=%0b vld=%0b last=%0b re=%h im=%h idx=%0d err=%0b required 1,0,0,0,0,0,0",
               req_ready, tw_valid, tw_last, tw_re, tw_im, tw_idx, stage_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stage3;
    logic [DATA_W-1:0] cre [8] = '{16'd256, 16'd237, 16'd181, 16'd98, 16'd0, 16'hFF9E, 16'hFF4B, 16'hFF13};
    logic [DATA_W-1:0] cim [8] = '{16'd0, 16'd98, 16'd181, 16'd237, 16'd256, 16'd237, 16'd181, 16'd98};
    int first, cnt;
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.re = cre[k]; e.im = cim[k]; e.idx = k; e.last = (k == 7);
      qa.push_back(e);
    end
    tw_ready = 1'b1;
    send_req(3);
    first = -1;
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (tw_valid) begin
        if (first < 0) first = c;
        cnt++;
      end else if (cnt > 0) begin
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (first !== 2) begin
      failures++;
      $display("[TB] FAIL stage3_latency got %0d required 2", first);
    end
    checks++;
    if (cnt !== 8) begin
      failures++;
      $display("[TB] FAIL stage3_valid_run got %0d required 8", cnt);
    end
    wait_drain_a("stage3");
  endtask

  task automatic test_stage0_stage1;
    push_model_a(0, 1'b0);
    send_req(0);
    wait_drain_a("stage0");
    push_model_a(1, 1'b0);
    send_req(1);
    wait_drain_a("stage1");
  endtask

  task automatic test_stall;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit stalled = 1'b0;
    logic [DATA_W-1:0] h_re, h_im;
    logic [LOG2_N-2:0] h_idx;
    logic h_last;
    int cyc = 0;
    push_model_a(2, 1'b0);
    tw_ready = 1'b1;
    send_req(2);
    while (!(qa.size() == 0 && req_ready) && cyc < 300) begin
      tw_ready = pat[cyc % 4];
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (tw_valid !== 1'b1 || tw_re !== h_re || tw_im !== h_im || tw_idx !== h_idx || tw_last !== h_last) begin
          failures++;
          $display("[TB] FAIL stall_hold got (vld=%0b re=%h im=%h idx=%0d last=%0b) required (1 %h %h %0d %0b)",
                   tw_valid, tw_re, tw_im, tw_idx, tw_last, h_re, h_im, h_idx, h_last);
        end
      end
      stalled = tw_valid && !tw_ready;
      h_re = tw_re; h_im = tw_im; h_idx = tw_idx; h_last = tw_last;
      @(posedge clk); #1;
      cyc++;
    end
    tw_ready = 1'b1;
    checks++;
    if (cyc >= 300) begin
      failures++;
      $display("[TB] FAIL stall_drain got pending=%0d required 0", qa.size());
    end
  endtask

  task automatic test_stage_err;
    tw_ready_b = 1'b1;
    push_model_b(5);
    send_req_b(5);
    checks++;
    if (stage_err_b !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stage_err_set got %0b required 1", stage_err_b);
    end
    for (int c = 0; c < 300 && !(qb.size() == 0 && req_ready_b); c++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (qb.size() != 0 || req_ready_b !== 1'b1 || stage_err_b !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stage_err_clamped_run got pending=%0d rdy=%0b err=%0b required 0,1,1",
               qb.size(), req_ready_b, stage_err_b);
    end
    push_model_b(1);
    send_req_b(1);
    checks++;
    if (stage_err_b !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stage_err_clear got %0b required 0", stage_err_b);
    end
    for (int c = 0; c < 300 && !(qb.size() == 0 && req_ready_b); c++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (qb.size() != 0 || req_ready_b !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stage_err_stage1_run got pending=%0d rdy=%0b required 0,1", qb.size(), req_ready_b);
    end
    checks++;
    if (stage_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stage_err_a got %0b required 0", stage_err);
    end
  endtask

  task automatic test_busy_ignore;
    push_model_a(1, 1'b0);
    send_req(1);
    req_valid = 1'b1;
    req_stage = SW'(0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (req_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL busy_req_ready got %0b required 0", req_ready);
      end
    end
    req_valid = 1'b0;
    wait_drain_a("busy");
  endtask

  task automatic test_back_to_back;
    int c = 0;
    push_model_a(0, 1'b0);
    push_model_a(3, 1'b0);
    send_req(0);
    while (!req_ready && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    checks++;
    if (qa.size() !== N / 2) begin
      failures++;
      $display("[TB] FAIL b2b_first_done got pending=%0d required %0d", qa.size(), N / 2);
    end
    send_req(3);
    wait_drain_a("b2b");
  endtask

  task automatic test_reset_midstream;
    int c = 0;
    push_model_a(3, 1'b0);
    send_req(3);
    while (qa.size() > N / 2 - 3 && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (tw_valid !== 1'b0 || req_ready !== 1'b1 || tw_last !== 1'b0 || c >= 100) begin
      failures++;
      $display("[TB] FAIL midstream_reset got vld=%0b rdy=%0b last=%0b wait=%0d required 0,1,0",
               tw_valid, req_ready, tw_last, c);
    end
    qa.delete();
    @(negedge clk);
    rst_n = 1'b1;
    push_model_a(3, 1'b0);
    send_req(3);
    wait_drain_a("after_reset");
  endtask

`ifdef TWIDDLE_INV_EN
  task automatic test_inv;
    push_model_a(3, 1'b1);
    req_inv = 1'b1;
    send_req(3);
    req_inv = 1'b0;
    wait_drain_a("inv");
  endtask
`endif

  initial begin
    req_valid = 1'b0; req_stage = '0; req_inv = 1'b0; tw_ready = 1'b1;
    req_valid_b = 1'b0; req_stage_b = '0; req_inv_b = 1'b0; tw_ready_b = 1'b1;
    test_reset();
    test_stage3();
    test_stage0_stage1();
    test_stall();
    test_stage_err();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midstream();
`ifdef TWIDDLE_INV_EN
    test_inv();
`endif
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      failures++;
      $display("[TB] FAIL final_queues got a=%0d b=%0d required 0,0", qa.size(), qb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog_timeout got no finish required finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule
